// File: rtl/mem_stall_ctrl.sv
// MEM-stage stall controller: runs one req/ack transaction to slow data memory per
// load/store and freezes the pipeline until that transaction completes or times out.
module mem_stall_ctrl #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic [DATA_W-1:0] rdata,
  output logic              bus_err,
  output logic [15:0]       stall_cnt,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_ack,
  input  logic [DATA_W-1:0] dm_rdata
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  // Value of the WAIT-cycle counter on the last WAIT cycle before the access is aborted.
  localparam logic [15:0] TmoLast = 16'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic [15:0]       tmo_q, tmo_d;
  logic              dm_req_q, dm_req_d;
  logic              dm_we_q, dm_we_d;
  logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
  logic [DATA_W-1:0] dm_wdata_q, dm_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              bus_err_q, bus_err_d;
  logic [15:0]       stall_cnt_q, stall_cnt_d;
  logic              access;

  // Both controls high is an illegal encoding; mem_write alone decides the direction.
  assign access = mem_read | mem_write;

  // Stall covers the accepting IDLE cycle plus every WAIT cycle; forced low in reset.
  always_comb begin
    stall = rst_n & (((state_q == StIdle) & access) | (state_q == StWait));
  end

  // Next-state logic for the access FSM and its registered memory-side outputs.
  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    dm_req_d   = dm_req_q;
    dm_we_d    = dm_we_q;
    dm_addr_d  = dm_addr_q;
    dm_wdata_d = dm_wdata_q;
    rdata_d    = rdata_q;
    bus_err_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (access) begin
          state_d    = StWait;
          dm_req_d   = 1'b1;
          dm_we_d    = mem_write;
          dm_addr_d  = addr;
          dm_wdata_d = wdata;
          tmo_d      = '0;
        end
      end
      StWait: begin
        // An ack arriving on the timeout cycle still completes the access normally.
        if (dm_ack) begin
          if (!dm_we_q) rdata_d = dm_rdata;
          dm_req_d = 1'b0;
          state_d  = StDone;
        end else if (tmo_q == TmoLast) begin
          rdata_d   = '0;
          bus_err_d = 1'b1;
          dm_req_d  = 1'b0;
          state_d   = StDone;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d  = StIdle;
        dm_req_d = 1'b0;
      end
    endcase
  end

  // Saturating count of stalled cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // State and output registers; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      tmo_q       <= '0;
      dm_req_q    <= 1'b0;
      dm_we_q     <= 1'b0;
      dm_addr_q   <= '0;
      dm_wdata_q  <= '0;
      rdata_q     <= '0;
      bus_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      dm_req_q    <= dm_req_d;
      dm_we_q     <= dm_we_d;
      dm_addr_q   <= dm_addr_d;
      dm_wdata_q  <= dm_wdata_d;
      rdata_q     <= rdata_d;
      bus_err_q   <= bus_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign dm_req    = dm_req_q;
  assign dm_we     = dm_we_q;
  assign dm_addr   = dm_addr_q;
  assign dm_wdata  = dm_wdata_q;
  assign rdata     = rdata_q;
  assign bus_err   = bus_err_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Scoreboard bench for mem_stall_ctrl: the driver pushes the expected completion of each
// access; a negedge monitor detects the DONE cycle and compares against the queue head.
module tb_mem_stall_ctrl;

  localparam int unsigned TMO = 4;

  typedef struct {
    logic [31:0] rdata;
    logic        bus_err;
    int          stall_cycles;
    logic [15:0] stall_cnt;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [31:0] addr, wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        bus_err;
  logic [15:0] stall_cnt;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  int errors = 0;
  int checks = 0;
  exp_t exp_q[$];

  mem_stall_ctrl #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(TMO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .addr     (addr),
    .wdata    (wdata),
    .stall    (stall),
    .rdata    (rdata),
    .bus_err  (bus_err),
    .stall_cnt(stall_cnt),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_ack   (dm_ack),
    .dm_rdata (dm_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: counts stall cycles and captures the request fields while dm_req is high.
  int          run_stall = 0;
  logic        req_prev = 1'b0;
  logic        seen_we;
  logic [31:0] seen_addr, seen_wdata;
  always @(negedge clk) begin
    if (!rst_n) begin
      run_stall = 0;
      req_prev  = 1'b0;
    end else begin
      if (stall) run_stall++;
      if (dm_req) begin
        seen_we    = dm_we;
        seen_addr  = dm_addr;
        seen_wdata = dm_wdata;
      end
      if (req_prev && !dm_req) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected: got a DONE cycle expected none");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rdata", rdata, e.rdata);
          check("bus_err", 32'(bus_err), 32'(e.bus_err));
          check("stall_cycles", 32'(run_stall), 32'(e.stall_cycles));
          check("stall_cnt", 32'(stall_cnt), 32'(e.stall_cnt));
          check("dm_we", 32'(seen_we), 32'(e.we));
          check("dm_addr", seen_addr, e.addr);
          check("dm_wdata", seen_wdata, e.wdata);
        end
        run_stall = 0;
      end
      req_prev = dm_req;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access; k >= 0 acks k cycles after dm_req rises, k < 0 never acks.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input int k, input logic [31:0] mem_val,
                        input exp_t e);
    exp_q.push_back(e);
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wdata     = wd;
    tick();
    check("req_rise", 32'(dm_req), 32'd1);
    if (k >= 0) begin
      for (int i = 0; i < k; i++) tick();
      dm_ack   = 1'b1;
      dm_rdata = mem_val;
      tick();
      dm_ack = 1'b0;
    end else begin
      for (int i = 0; i < 20 && dm_req; i++) tick();
      check("timeout_exit", 32'(dm_req), 32'd0);
    end
    // DONE cycle: the pipeline advances past this instruction.
    mem_read  = 1'b0;
    mem_write = 1'b0;
    tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_read  = 1'b1;
    mem_write = 1'b0;
    addr      = '0;
    wdata     = '0;
    dm_ack    = 1'b0;
    dm_rdata  = '0;
    #12;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_dm_req", 32'(dm_req), 32'd0);
    check("rst_dm_we", 32'(dm_we), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    mem_read = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Load, ack 3 cycles after dm_req: 5 stall cycles.
    access(1'b1, 1'b0, 32'h40, 32'h0, 3, 32'h12345678,
           '{32'h12345678, 1'b0, 5, 16'd5, 1'b0, 32'h40, 32'h0});
    // Store acked in first WAIT cycle: 2 stall cycles, rdata untouched.
    access(1'b0, 1'b1, 32'h80, 32'hCAFEF00D, 0, 32'hDEADBEEF,
           '{32'h12345678, 1'b0, 2, 16'd7, 1'b1, 32'h80, 32'hCAFEF00D});
    // No ack: abort after TMO WAIT cycles.
    access(1'b1, 1'b0, 32'h100, 32'h0, -1, 32'h0,
           '{32'h0, 1'b1, 5, 16'd12, 1'b0, 32'h100, 32'h0});
    // Ack on the timeout cycle wins.
    access(1'b1, 1'b0, 32'h104, 32'h0, TMO - 1, 32'hA5A55A5A,
           '{32'hA5A55A5A, 1'b0, 5, 16'd17, 1'b0, 32'h104, 32'h0});
    // Illegal read+write treated as a write.
    access(1'b1, 1'b1, 32'h200, 32'h11223344, 1, 32'h55555555,
           '{32'hA5A55A5A, 1'b0, 3, 16'd20, 1'b1, 32'h200, 32'h11223344});

    // Stray ack while idle.
    dm_ack   = 1'b1;
    dm_rdata = 32'hFFFFFFFF;
    tick();
    dm_ack = 1'b0;
    tick();
    check("stray_rdata", rdata, 32'hA5A55A5A);
    check("stray_stall_cnt", 32'(stall_cnt), 32'd20);
    check("stray_dm_req", 32'(dm_req), 32'd0);

    // Reset in the middle of WAIT.
    mem_read = 1'b1;
    addr     = 32'h300;
    tick();
    check("pre_rst_req", 32'(dm_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_dm_req", 32'(dm_req), 32'd0);
    check("mid_rst_stall", 32'(stall), 32'd0);
    check("mid_rst_stall_cnt", 32'(stall_cnt), 32'd0);
    tick();
    mem_read = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_dm_req", 32'(dm_req), 32'd0);
    check("post_rst_stall", 32'(stall), 32'd0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending: got %0d outstanding expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
